i2c_reg_transactor: RTL and testbench
=====================================

// Module: i2c_reg_transactor
// PURPOSE
//  Sequencer directly upstream of the WB I2C master controller: turns one register-level
//  command (device, register, data, read/write) into the ordered series of single WB
//  register accesses an OpenCores-style i2c_master core needs. It drives the controller's
//  ren/wren/addr/data request inputs and consumes its data, data_val and done outputs.
//  It also initialises the core (prescaler, enable) after reset.
// PARAMETERS
//  PRESCALE      16'd99  value written to PRERhi:PRERlo (clk/(5*SCL)-1)
//  TIMEOUT_POLLS 1024    max SR reads per TIP poll before abort
// PORTS
//  i_clk        in   1   clock
//  i_reset      in   1   synchronous, active-high reset
//  i_start      in   1   command strobe; accepted only when o_busy=0
//  i_rnw        in   1   1=register read, 0=register write
//  i_dev_addr   in   7   7-bit I2C device address
//  i_reg_addr   in   8   device register index
//  i_wdata      in   8   write data
//  o_busy       out  1   init or command in progress
//  o_done       out  1   1-cycle pulse at command end
//  o_rdata      out  8   read result; valid at o_done when i_rnw=1
//  o_nack       out  1   valid with o_done: slave NACKed
//  o_timeout    out  1   valid with o_done: TIP poll exceeded TIMEOUT_POLLS
//  o_ren        out  1   1-cycle WB read request to controller
//  o_wren       out  1   1-cycle WB write request to controller
//  o_addr       out  3   WB register address
//  o_wdata      out  8   WB write data
//  i_rdata      in   8   controller read data
//  i_rdata_val  in   1   controller read data valid
//  i_done       in   1   controller access complete (WB ack)
// BEHAVIOUR
//  - Reset: o_busy=1; o_done, o_nack, o_timeout, o_ren, o_wren = 0; o_addr, o_wdata,
//    o_rdata = 0. FSM enters INIT. Reset mid-op aborts and restarts INIT; no o_done.
//  - WB op: o_ren or o_wren high exactly 1 cycle with o_addr/o_wdata stable, then wait for
//    i_done. Next request no earlier than the cycle after i_done. Never >1 outstanding.
//  - INIT: write 0<=PRESCALE[7:0], 1<=PRESCALE[15:8], 2<=0x80 (EN); then IDLE, o_busy=0.
//  - IDLE: i_start && !o_busy latches all command inputs; o_busy=1 next cycle.
//    i_start while busy is ignored.
//  - Byte phase B(tx,cr): write 3<=tx, write 4<=cr, then POLL: read 4 (SR) until bit1
//    (TIP)=0. Then CHECK: SR bit7 (RxACK)=1 -> NACK abort.
//  - Write cmd: B({dev,0},0x90); B(reg,0x10); B(wdata,0x50); DONE.
//  - Read cmd: B({dev,0},0x90); B(reg,0x10); B({dev,1},0x90); write 4<=0x68
//    (RD|NACK|STO); POLL; read 3 (RXR) -> o_rdata; DONE.
//    No RxACK check after the final read byte.
//  - NACK abort: write 4<=0x40 (STO); POLL; DONE with o_nack=1.
//  - Timeout: poll counter counts SR reads per POLL, cleared on entry.
//    Reaching TIMEOUT_POLLS -> write 4<=0x40; DONE with o_timeout=1; no further polling.
//  - DONE: o_done=1 for 1 cycle with o_nack/o_timeout/o_rdata valid; o_busy=0 same cycle.
//    o_nack/o_timeout hold until next accepted i_start.
//    o_rdata holds until next read completes.
//  - Only i_rdata_val-qualified i_rdata is sampled (SR/RXR reads).
// TESTING
//  - PRESCALE=99, release reset -> WB writes (0,0x63),(1,0x00),(2,0x80) in order;
//    o_busy falls after the 3rd i_done.
//  - Write dev=0x50 reg=0x10 data=0xA5, model ACKs, TIP clears after 3 polls ->
//    TXR 0xA0/0x10/0xA5 with CR 0x90/0x10/0x50; o_done with o_nack=0.
//  - Read dev=0x50 reg=0x10, model RXR=0x3C -> TXR 0xA0,0x10,0xA1; CR 0x90,0x10,0x90,0x68;
//    o_rdata=0x3C at o_done.
//  - Model RxACK=1 on address byte -> next write is 4<=0x40; no further TXR writes;
//    o_done with o_nack=1.
//  - TIP stuck 1, TIMEOUT_POLLS=8 -> exactly 8 SR reads, then 4<=0x40; o_timeout=1.
//  - i_start pulsed while busy -> ignored. i_reset mid-read -> requests stop, no o_done,
//    INIT writes repeat.

Source files
------------

// File: rtl/i2c_reg_transactor_if.sv
// rtl/i2c_reg_transactor_if.sv - single-access WB request/response bus to the I2C master core
interface i2c_reg_transactor_if;
  logic       ren;
  logic       wren;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_val;
  logic       done;

  modport master (output ren, wren, addr, wdata, input rdata, rdata_val, done);
  modport slave  (input ren, wren, addr, wdata, output rdata, rdata_val, done);
endinterface

// File: rtl/i2c_reg_transactor.sv
// rtl/i2c_reg_transactor.sv - turns one I2C register command into i2c_master core WB accesses
module i2c_reg_transactor #(
  parameter logic [15:0] PRESCALE      = 16'd99,
  parameter int          TIMEOUT_POLLS = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic                        i_rnw,
  input  logic [6:0]                  i_dev_addr,
  input  logic [7:0]                  i_reg_addr,
  input  logic [7:0]                  i_wdata,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [7:0]                  o_rdata,
  output logic                        o_nack,
  output logic                        o_timeout,
  i2c_reg_transactor_if.master        wb
);
  localparam logic [2:0] A_PRERLO = 3'd0;
  localparam logic [2:0] A_PRERHI = 3'd1;
  localparam logic [2:0] A_CTR    = 3'd2;
  localparam logic [2:0] A_TXRXR  = 3'd3;
  localparam logic [2:0] A_CRSR   = 3'd4;
  localparam logic [7:0] CTR_EN   = 8'h80;
  localparam logic [7:0] CR_STO   = 8'h40;
  localparam int         PCW      = $clog2(TIMEOUT_POLLS + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(TIMEOUT_POLLS - 1);

  typedef enum logic [3:0] {
    S_INIT_PRL, S_INIT_PRH, S_INIT_CTR, S_IDLE,
    S_TX_WR, S_CR_WR, S_POLL_RD, S_RX_RD, S_STOP_WR
  } state_t;

  state_t         state_q, state_d;
  logic           wait_q, wait_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [1:0]     byte_q, byte_d;
  logic           rnw_q, rnw_d;
  logic [6:0]     dev_q, dev_d;
  logic [7:0]     reg_q, reg_d;
  logic [7:0]     cmd_wdata_q, cmd_wdata_d;
  logic           stopping_q, stopping_d;
  logic [7:0]     hold_q, hold_d;
  logic           ren_d, wren_d, busy_d, done_d, nack_d, tout_d;
  logic [2:0]     addr_d;
  logic [7:0]     wdata_d, rdata_d;
  logic [7:0]     rd_cur, tx_byte, cr_byte;

  // Byte 3 exists only for reads: the data byte, clocked in with NACK and STOP.
  always_comb begin
    tx_byte = {dev_q, 1'b0};
    cr_byte = 8'h90;
    case (byte_q)
      2'd1: begin
        tx_byte = reg_q;
        cr_byte = 8'h10;
      end
      2'd2: begin
        tx_byte = rnw_q ? {dev_q, 1'b1} : cmd_wdata_q;
        cr_byte = rnw_q ? 8'h90 : 8'h50;
      end
      2'd3: cr_byte = 8'h68;
      default: ;
    endcase
  end

  // Read data may arrive with or before the ack, so use it live when valid.
  assign rd_cur = wb.rdata_val ? wb.rdata : hold_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    poll_d      = poll_q;
    byte_d      = byte_q;
    rnw_d       = rnw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    cmd_wdata_d = cmd_wdata_q;
    stopping_d  = stopping_q;
    hold_d      = (wait_q && wb.rdata_val) ? wb.rdata : hold_q;
    ren_d       = 1'b0;
    wren_d      = 1'b0;
    addr_d      = wb.addr;
    wdata_d     = wb.wdata;
    busy_d      = o_busy;
    done_d      = 1'b0;
    nack_d      = o_nack;
    tout_d      = o_timeout;
    rdata_d     = o_rdata;

    if (state_q == S_IDLE) begin
      if (i_start) begin
        rnw_d       = i_rnw;
        dev_d       = i_dev_addr;
        reg_d       = i_reg_addr;
        cmd_wdata_d = i_wdata;
        byte_d      = 2'd0;
        stopping_d  = 1'b0;
        nack_d      = 1'b0;
        tout_d      = 1'b0;
        busy_d      = 1'b1;
        state_d     = S_TX_WR;
      end
    end else if (!wait_q) begin
      wait_d = 1'b1;
      wren_d = 1'b1;
      case (state_q)
        S_INIT_PRL: begin addr_d = A_PRERLO; wdata_d = PRESCALE[7:0];  end
        S_INIT_PRH: begin addr_d = A_PRERHI; wdata_d = PRESCALE[15:8]; end
        S_INIT_CTR: begin addr_d = A_CTR;    wdata_d = CTR_EN;         end
        S_TX_WR:    begin addr_d = A_TXRXR;  wdata_d = tx_byte;        end
        S_CR_WR:    begin addr_d = A_CRSR;   wdata_d = cr_byte;        end
        S_POLL_RD:  begin wren_d = 1'b0; ren_d = 1'b1; addr_d = A_CRSR;  end
        S_RX_RD:    begin wren_d = 1'b0; ren_d = 1'b1; addr_d = A_TXRXR; end
        default:    begin addr_d = A_CRSR;   wdata_d = CR_STO;         end
      endcase
    end else if (wb.done) begin
      wait_d = 1'b0;
      case (state_q)
        S_INIT_PRL: state_d = S_INIT_PRH;
        S_INIT_PRH: state_d = S_INIT_CTR;
        S_INIT_CTR: begin state_d = S_IDLE; busy_d = 1'b0; end
        S_TX_WR:    state_d = S_CR_WR;
        S_CR_WR:    begin state_d = S_POLL_RD; poll_d = '0; end
        S_POLL_RD: begin
          if (rd_cur[1]) begin
            if (poll_q == POLL_LAST) begin
              tout_d  = 1'b1;
              state_d = S_STOP_WR;
            end else begin
              poll_d = poll_q + PCW'(1);
            end
          end else if (stopping_q) begin
            state_d = S_IDLE; busy_d = 1'b0; done_d = 1'b1;
          end else if (byte_q == 2'd3) begin
            state_d = S_RX_RD;
          end else if (rd_cur[7]) begin
            nack_d     = 1'b1;
            stopping_d = 1'b1;
            state_d    = S_STOP_WR;
          end else if (byte_q == 2'd2 && !rnw_q) begin
            state_d = S_IDLE; busy_d = 1'b0; done_d = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = (byte_q == 2'd2) ? S_CR_WR : S_TX_WR;
          end
        end
        S_RX_RD: begin
          rdata_d = rd_cur;
          state_d = S_IDLE; busy_d = 1'b0; done_d = 1'b1;
        end
        default: begin
          // After a timeout STOP the bus is presumed stuck: finish without polling.
          if (o_timeout) begin
            state_d = S_IDLE; busy_d = 1'b0; done_d = 1'b1;
          end else begin
            state_d = S_POLL_RD;
            poll_d  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_INIT_PRL;
      wait_q      <= 1'b0;
      poll_q      <= '0;
      byte_q      <= 2'd0;
      rnw_q       <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      cmd_wdata_q <= 8'd0;
      stopping_q  <= 1'b0;
      hold_q      <= 8'd0;
      wb.ren      <= 1'b0;
      wb.wren     <= 1'b0;
      wb.addr     <= 3'd0;
      wb.wdata    <= 8'd0;
      o_busy      <= 1'b1;
      o_done      <= 1'b0;
      o_nack      <= 1'b0;
      o_timeout   <= 1'b0;
      o_rdata     <= 8'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      poll_q      <= poll_d;
      byte_q      <= byte_d;
      rnw_q       <= rnw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      cmd_wdata_q <= cmd_wdata_d;
      stopping_q  <= stopping_d;
      hold_q      <= hold_d;
      wb.ren      <= ren_d;
      wb.wren     <= wren_d;
      wb.addr     <= addr_d;
      wb.wdata    <= wdata_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
      o_nack      <= nack_d;
      o_timeout   <= tout_d;
      o_rdata     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_i2c_reg_transactor.sv
// tb/tb_i2c_reg_transactor.sv - randomized bench with i2c_master core model and access-sequence reference
module tb_i2c_reg_transactor;
  localparam int TO = 8;

  typedef struct packed {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
  } acc_t;

  logic       clk;
  logic       rst;
  logic       start, rnw;
  logic [6:0] dev;
  logic [7:0] regi, wdat;
  logic       busy, done, nack, tout;
  logic [7:0] rdata;

  i2c_reg_transactor_if wb();

  i2c_reg_transactor #(.PRESCALE(16'd99), .TIMEOUT_POLLS(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_rnw(rnw),
    .i_dev_addr(dev), .i_reg_addr(regi), .i_wdata(wdat),
    .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_nack(nack), .o_timeout(tout),
    .wb(wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  acc_t exp_q[$];
  bit   exp_nack, exp_tout, exp_rd_valid;
  logic [7:0] exp_rd;
  logic hold_nack, hold_tout;
  logic [7:0] hold_rd;
  bit   cmd_active, done_seen;
  // core model configuration for the current command
  int   tip_cfg, nack_cfg, cr_idx, busy_cnt;
  logic [7:0] rxr_cfg;
  logic rxack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic acc_t mk(input logic w, input logic [2:0] a, input logic [7:0] d);
    acc_t e;
    e.wr = w; e.addr = a; e.data = d;
    return e;
  endfunction

  // One TIP poll: tips busy reads then a clear one, unless the poll limit cuts it short.
  function automatic bit add_poll(input int tips);
    int n;
    n = (tips >= TO) ? TO : tips + 1;
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 3'd4, 8'h00));
    if (tips >= TO) begin
      exp_q.push_back(mk(1'b1, 3'd4, 8'h40));
      exp_tout = 1'b1;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void build_cmd(input bit r, input logic [6:0] d, input logic [7:0] rg,
                                    input logic [7:0] wd, input int tips, input int nk,
                                    input logic [7:0] rx);
    logic [7:0] tx, cr;
    exp_q.delete();
    exp_nack = 1'b0; exp_tout = 1'b0; exp_rd_valid = 1'b0; exp_rd = 8'h00;
    for (int b = 0; b < 3; b++) begin
      tx = (b == 0) ? {d, 1'b0} : (b == 1) ? rg : (r ? {d, 1'b1} : wd);
      cr = (b == 1) ? 8'h10 : ((b == 2 && !r) ? 8'h50 : 8'h90);
      exp_q.push_back(mk(1'b1, 3'd3, tx));
      exp_q.push_back(mk(1'b1, 3'd4, cr));
      if (!add_poll(tips)) return;
      if (nk == b) begin
        exp_nack = 1'b1;
        exp_q.push_back(mk(1'b1, 3'd4, 8'h40));
        void'(add_poll(tips));
        return;
      end
    end
    if (r) begin
      exp_q.push_back(mk(1'b1, 3'd4, 8'h68));
      if (!add_poll(tips)) return;
      exp_q.push_back(mk(1'b0, 3'd3, 8'h00));
      exp_rd_valid = 1'b1;
      exp_rd = rx;
    end
  endfunction

  // Core model plus the single compare process, both at the negative edge.
  initial begin
    bit   pend, pend_rd, prev_req, req;
    int   lat;
    logic [7:0] pend_val;
    logic [4:0] junk5;
    acc_t e;
    pend = 0; pend_rd = 0; prev_req = 0; lat = 0; pend_val = 0;
    wb.done = 1'b0; wb.rdata_val = 1'b0; wb.rdata = 8'h00;
    hold_nack = 0; hold_tout = 0; hold_rd = 0; rxack = 0; busy_cnt = 0;
    forever begin
      @(negedge clk);
      wb.done = 1'b0;
      wb.rdata_val = 1'b0;
      wb.rdata = 8'($urandom);
      if (rst === 1'b1) begin
        pend = 0; prev_req = 0;
        hold_nack = 0; hold_tout = 0; hold_rd = 0;
      end else begin
        req = (wb.ren === 1'b1) || (wb.wren === 1'b1);
        if (req) begin
          check("wb_one_outstanding", {pend, prev_req, wb.ren & wb.wren}, 0);
          check("wb_access_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wb_kind", wb.wren, e.wr);
            check("wb_addr", wb.addr, e.addr);
            if (e.wr) check("wb_wdata", wb.wdata, e.data);
          end
          if (wb.wren && wb.addr == 3'd4) begin
            busy_cnt = tip_cfg;
            if (wb.wdata[4]) begin rxack = (cr_idx == nack_cfg); cr_idx++; end
            if (wb.wdata[5]) rxack = 1'($urandom);
          end
          pend_val = 8'h00;
          if (wb.ren && wb.addr == 3'd4) begin
            junk5 = 5'($urandom);
            pend_val = {rxack, junk5, busy_cnt != 0, 1'($urandom)};
            if (busy_cnt > 0) busy_cnt--;
          end else if (wb.ren && wb.addr == 3'd3) begin
            pend_val = rxr_cfg;
          end
          pend = 1; pend_rd = wb.ren; lat = $urandom_range(0, 2);
        end else if (pend) begin
          if (lat == 0) begin
            wb.done = 1'b1;
            if (pend_rd) begin wb.rdata_val = 1'b1; wb.rdata = pend_val; end
            pend = 0;
          end else lat--;
        end
        prev_req = req;

        if (done === 1'b1) begin
          check("done_expected", cmd_active, 1);
          check("done_accesses_left", exp_q.size(), 0);
          check("done_busy", busy, 0);
          check("done_nack", nack, exp_nack);
          check("done_timeout", tout, exp_tout);
          check("done_rdata", rdata, exp_rd_valid ? exp_rd : hold_rd);
          hold_nack = exp_nack; hold_tout = exp_tout;
          if (exp_rd_valid) hold_rd = exp_rd;
          cmd_active = 0; done_seen = 1;
        end else if (busy === 1'b0) begin
          check("idle_nack_hold", nack, hold_nack);
          check("idle_timeout_hold", tout, hold_tout);
          check("idle_rdata_hold", rdata, hold_rd);
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    int i;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    exp_q.delete(); cmd_active = 0;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_ren", wb.ren, 0);
    check("rst_wren", wb.wren, 0);
    check("rst_addr", wb.addr, 0);
    check("rst_wdata", wb.wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_nack", nack, 0);
    check("rst_timeout", tout, 0);
    exp_q.push_back(mk(1'b1, 3'd0, 8'h63));
    exp_q.push_back(mk(1'b1, 3'd1, 8'h00));
    exp_q.push_back(mk(1'b1, 3'd2, 8'h80));
    rst = 1'b0;
    i = 0;
    while (busy !== 1'b0 && i < 200) begin @(posedge clk); #1; i++; end
    check("init_busy_falls", busy, 0);
    check("init_writes_left", exp_q.size(), 0);
  endtask

  task automatic run_cmd(input bit r, input logic [6:0] d, input logic [7:0] rg,
                         input logic [7:0] wd, input int tips, input int nk,
                         input logic [7:0] rx, input bit poke);
    int i;
    @(posedge clk); #1;
    tip_cfg = tips; nack_cfg = nk; rxr_cfg = rx; cr_idx = 0; rxack = 0;
    build_cmd(r, d, rg, wd, tips, nk, rx);
    done_seen = 0; cmd_active = 1;
    start = 1'b1; rnw = r; dev = d; regi = rg; wdat = wd;
    @(posedge clk); #1;
    start = 1'b0; rnw = 1'($urandom); dev = 7'($urandom); regi = 8'($urandom); wdat = 8'($urandom);
    if (poke) begin
      repeat (5) @(posedge clk);
      #1; start = 1'b1; rnw = ~r;
      @(posedge clk); #1; start = 1'b0;
    end
    i = 0;
    while (!done_seen && i < 3000) begin @(posedge clk); #1; i++; end
    check("cmd_completes", done_seen, 1);
    if (!done_seen) do_reset(2);
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rnw = 0; dev = 0; regi = 0; wdat = 0;
    cmd_active = 0; done_seen = 0; tip_cfg = 0; nack_cfg = -1; cr_idx = 0; rxr_cfg = 0;

    build_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 3, -1, 8'h00);
    check("model_wr_len", exp_q.size(), 18);
    check("model_wr_0", exp_q[0], {1'b1, 3'd3, 8'hA0});
    check("model_wr_1", exp_q[1], {1'b1, 3'd4, 8'h90});
    check("model_wr_6", exp_q[6], {1'b1, 3'd3, 8'h10});
    check("model_wr_13", exp_q[13], {1'b1, 3'd4, 8'h50});
    build_cmd(1'b1, 7'h50, 8'h10, 8'h00, 0, -1, 8'h3C);
    check("model_rd_len", exp_q.size(), 12);
    check("model_rd_6", exp_q[6], {1'b1, 3'd3, 8'hA1});
    check("model_rd_9", exp_q[9], {1'b1, 3'd4, 8'h68});
    build_cmd(1'b0, 7'h50, 8'h10, 8'h00, 0, 0, 8'h00);
    check("model_nack_len", exp_q.size(), 5);
    check("model_nack_3", exp_q[3], {1'b1, 3'd4, 8'h40});
    build_cmd(1'b0, 7'h50, 8'h10, 8'h00, 100, -1, 8'h00);
    check("model_to_len", exp_q.size(), 11);
    check("model_to_flag", exp_tout, 1);
    exp_q.delete();

    do_reset(3);
    run_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 3, -1, 8'h00, 1'b0);
    run_cmd(1'b1, 7'h50, 8'h10, 8'h00, 1, -1, 8'h3C, 1'b0);
    run_cmd(1'b0, 7'h50, 8'h10, 8'h77, 0, 0, 8'h00, 1'b0);
    run_cmd(1'b1, 7'h2A, 8'h01, 8'h00, 1000, -1, 8'h55, 1'b0);
    run_cmd(1'b0, 7'h11, 8'h22, 8'h33, 2, -1, 8'h00, 1'b1);

    @(posedge clk); #1;
    tip_cfg = 2; nack_cfg = -1; rxr_cfg = 8'hEE; cr_idx = 0;
    build_cmd(1'b1, 7'h50, 8'h10, 8'h00, 2, -1, 8'hEE);
    cmd_active = 1; start = 1'b1; rnw = 1'b1; dev = 7'h50; regi = 8'h10;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    do_reset(2);

    for (int k = 0; k < 40; k++) begin
      int nk;
      nk = $urandom_range(0, 5);
      if (nk > 2) nk = -1;
      run_cmd(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 9), nk, 8'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end
endmodule
